axi4_mem_responder: RTL and testbench
=====================================

# axi4_mem_responder

AXI4 subordinate (responder) memory model that terminates the SoC's 64-bit AXI4 data bus in validation benches. It sits on the far end of the core's memory bus: it accepts AW/W bursts and answers with B, and accepts AR bursts and answers with R beats from an internal byte-enabled RAM. Read and write paths run as independent single-outstanding state machines.
## Interface
- ADDR_W, 32, byte-address width of bus_awaddr/bus_araddr
- ID_W, 16, transaction ID width; IDs echoed unchanged
- WORDS, 4096, RAM depth in 64-bit words (power of 2); word index = addr[3 +: log2(WORDS)], upper bits alias
- clk  in  1  clock; one clock domain; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- bus_awvalid  in  1  write-address valid
- bus_awready  out  1  write-address ready
- bus_awaddr  in  ADDR_W  burst start byte address (bits [2:0] ignored)
- bus_awid  in  ID_W  write ID
- bus_awlen  in  8  beats minus one
- bus_wvalid  in  1  write-data valid
- bus_wready  out  1  write-data ready
- bus_wdata  in  64  write data
- bus_wstrb  in  8  byte strobes
- bus_wlast  in  1  final write beat marker
- bus_bvalid  out  1  write response valid
- bus_bready  in  1  write response ready
- bus_bid  out  ID_W  echoed bus_awid
- bus_bresp  out  2  OKAY 2'b00 or SLVERR 2'b10
- bus_arvalid  in  1  read-address valid
- bus_arready  out  1  read-address ready
- bus_araddr  in  ADDR_W  burst start byte address (bits [2:0] ignored)
- bus_arid  in  ID_W  read ID
- bus_arlen  in  8  beats minus one
- bus_rvalid  out  1  read-data valid
- bus_rready  in  1  read-data ready
- bus_rdata  out  64  read data
- bus_rid  out  ID_W  echoed bus_arid
- bus_rresp  out  2  always OKAY 2'b00
- bus_rlast  out  1  high on beat len of the burst
## Operation
- Supported: INCR bursts, 8-byte beats only (master always drives size=3, burst=INCR; those signals are not ports). Word index increments by 1 per beat, wraps modulo WORDS.
- Write FSM: W_IDLE (awready=1) -> on AW handshake latch id/addr/len, beat count=0 -> W_DATA (wready=1); each W handshake writes wdata under wstrb, count++ -> on beat count==len go W_RESP (bvalid=1) -> on bready return W_IDLE.
- Burst length governed by bus_awlen only. bresp=OKAY iff wlast high on beat len and low on all earlier beats; otherwise SLVERR (data still written, burst still ends at beat len).
- Read FSM: R_IDLE (arready=1) -> on AR handshake latch id/addr/len -> R_FETCH (RAM read issued) -> R_DATA (rvalid=1, rdata/rid/rlast stable) -> on rready: if beat==len go R_IDLE, else beat++, addr++, go R_FETCH.
- Simultaneous write and read of the same word in one cycle: read returns old data (read-first).
- All outputs registered. rvalid/bvalid held with payload stable until handshake; never deasserted without it.
- Reset: awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, bid/rid/rdata=0, bresp/rresp=0, both FSMs to IDLE; RAM contents not reset. Reset mid-burst abandons the burst with no response.
## Timing
- First cycle after rst falls: awready=1, arready=1.
- Write: AW handshake cycle T -> wready from T+1; one beat per cycle; final beat at cycle U -> bvalid at U+1; B handshake at V -> awready at V+1.
- Read: AR handshake T -> rvalid at T+2; R handshake at N -> next rvalid at N+2 (throughput 1 beat / 2 cycles); last handshake at N -> arready at N+1.
## Structure
- Shared package axi4_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write/read FSM state enums.
- One sub-module sram_1r1w: WORDS x 64, byte-enabled write port, registered read port, read-first collision.
## Test plan
- Single write addr 0x10, len 0, data 0x1122334455667788, strb 0xFF, wlast=1 -> bresp OKAY, bid echoed; read 0x10 len 0 -> rdata 0x1122334455667788, rlast=1 at T+2.
- Write len 3 at 0x100, strb 0x0F on beat 1 over prior 0xFFFF...F -> read len 3 shows beat 1 = 0xFFFFFFFF_<new low word>, rlast only on beat 3.
- Write len 1 with wlast on beat 0 -> both beats written, bresp SLVERR; len 1 with no wlast -> SLVERR.
- rready held low 5 cycles on beat 0, bready low 3 cycles -> rvalid/bvalid and payloads stable throughout, no lost beat.
- Concurrent AW and AR to same word same cycle -> read returns pre-write value; later read returns new value.
- Assert rst during read beat 2 of len 7 -> next cycle rvalid=0; after release arready=1 and fresh burst reads correctly.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 constants and FSM state encodings for the memory responder.
package axi4_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LEN_W  = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

endpackage

// File: rtl/axi4_mem_responder_if.sv
// AXI4 bus bundle (INCR, 8-byte beats) between the core master and the memory responder.
interface axi4_mem_responder_if
  import axi4_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 16
);

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [LEN_W-1:0]  awlen;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [LEN_W-1:0]  arlen;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output awvalid, awaddr, awid, awlen,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arid, arlen,
    output rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arid, arlen,
    input  rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rdata, rid, rresp, rlast
  );

endinterface

// File: rtl/axi4_mem_responder_sram_1r1w.sv
// WORDS x 64 RAM: byte-enabled write port, registered read port, read-first on collision.
module sram_1r1w
  import axi4_pkg::*;
#(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned IDX_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;

  // Byte-lane write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Registered read; sampling before the same-edge write gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 memory responder: independent single-outstanding write and read FSMs over one RAM.
module axi4_mem_responder
  import axi4_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 16,
  parameter int unsigned WORDS  = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  axi4_mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(WORDS);

  w_state_e          r_wstate;
  logic              r_awready;
  logic              r_wready;
  logic              r_bvalid;
  logic [ID_W-1:0]   r_bid;
  logic [1:0]        r_bresp;
  logic [IDX_W-1:0]  r_widx;
  logic [LEN_W-1:0]  r_wlen;
  logic [LEN_W-1:0]  r_wcnt;
  logic              r_werr;

  r_state_e          r_rstate;
  logic              r_arready;
  logic              r_rvalid;
  logic              r_rlast;
  logic [ID_W-1:0]   r_rid;
  logic [IDX_W-1:0]  r_ridx;
  logic [LEN_W-1:0]  r_rlen;
  logic [LEN_W-1:0]  r_rcnt;

  logic              w_we;
  logic              w_re;
  logic              w_wbeat_last;
  logic              w_werr_next;
  logic [DATA_W-1:0] w_rdata;
  logic [2*ADDR_W-1:0] w_unused_addr;

  assign w_we          = (r_wstate == W_DATA) && bus.wvalid;
  assign w_re          = (r_rstate == R_FETCH);
  assign w_wbeat_last  = (r_wcnt == r_wlen);
  // A burst is malformed if wlast is missing on the final beat or appears early.
  assign w_werr_next   = r_werr | (bus.wlast ^ w_wbeat_last);
  assign w_unused_addr = {bus.awaddr, bus.araddr};

  sram_1r1w #(.WORDS(WORDS), .IDX_W(IDX_W)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_widx),
    .i_wdata (bus.wdata),
    .i_wstrb (bus.wstrb),
    .i_re    (w_re),
    .i_raddr (r_ridx),
    .o_rdata (w_rdata)
  );

  // Write FSM: AW accept, one W beat per cycle, then hold B until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
      r_widx    <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (r_awready && bus.awvalid) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= bus.awid;
            r_widx    <= bus.awaddr[3 +: IDX_W];
            r_wlen    <= bus.awlen;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (bus.wvalid) begin
            r_wcnt <= r_wcnt + LEN_W'(1);
            r_widx <= r_widx + IDX_W'(1);
            r_werr <= w_werr_next;
            if (w_wbeat_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_werr_next ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: AR accept, one RAM fetch per beat, hold R until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (r_arready && bus.arvalid) begin
            r_arready <= 1'b0;
            r_rid     <= bus.arid;
            r_ridx    <= bus.araddr[3 +: IDX_W];
            r_rlen    <= bus.arlen;
            r_rcnt    <= '0;
            r_rstate  <= R_FETCH;
          end
        end
        R_FETCH: begin
          r_rvalid <= 1'b1;
          r_rlast  <= (r_rcnt == r_rlen);
          r_rstate <= R_DATA;
        end
        R_DATA: begin
          if (bus.rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (r_rcnt == r_rlen) begin
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_rcnt   <= r_rcnt + LEN_W'(1);
              r_ridx   <= r_ridx + IDX_W'(1);
              r_rstate <= R_FETCH;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign bus.awready = r_awready;
  assign bus.wready  = r_wready;
  assign bus.bvalid  = r_bvalid;
  assign bus.bid     = r_bid;
  assign bus.bresp   = r_bresp;
  assign bus.arready = r_arready;
  assign bus.rvalid  = r_rvalid;
  assign bus.rdata   = w_rdata;
  assign bus.rid     = r_rid;
  assign bus.rresp   = RESP_OKAY;
  assign bus.rlast   = r_rlast;

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder with hand-computed expectations.
module tb_axi4_mem_responder;
  import axi4_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [63:0] wd [8];
  logic [7:0]  ws [8];
  logic        wl [8];
  logic [63:0] er [8];

  axi4_mem_responder_if #(.ADDR_W(32), .ID_W(16)) bus ();

  axi4_mem_responder #(.ADDR_W(32), .ID_W(16), .WORDS(4096)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fill beat tables: data base+i, full strobes, wlast only on beat len.
  task automatic set_beats(input logic [63:0] base, input int len);
    for (int i = 0; i < 8; i++) begin
      wd[i] = base + 64'(i);
      ws[i] = 8'hFF;
      wl[i] = (i == len);
      er[i] = base + 64'(i);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [15:0] id, input int len,
                          input int bdelay, input logic [1:0] exp_resp);
    int t;
    bus.awvalid = 1'b1;
    bus.awaddr  = addr;
    bus.awid    = id;
    bus.awlen   = 8'(len);
    t = 0;
    while (bus.awready !== 1'b1 && t < 50) begin step(); t++; end
    check("aw_ready_wait", 64'(t < 50), 64'd1);
    step();
    bus.awvalid = 1'b0;
    check("wready_after_aw", 64'(bus.wready), 64'd1);
    for (int i = 0; i <= len; i++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = wd[i];
      bus.wstrb  = ws[i];
      bus.wlast  = wl[i];
      step();
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    check("bvalid", 64'(bus.bvalid), 64'd1);
    check("bid", 64'(bus.bid), 64'(id));
    check("bresp", 64'(bus.bresp), 64'(exp_resp));
    for (int d = 0; d < bdelay; d++) begin
      step();
      check("bvalid_hold", 64'(bus.bvalid), 64'd1);
      check("bid_hold", 64'(bus.bid), 64'(id));
      check("bresp_hold", 64'(bus.bresp), 64'(exp_resp));
    end
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    check("bvalid_drop", 64'(bus.bvalid), 64'd0);
    check("awready_after_b", 64'(bus.awready), 64'd1);
  endtask

  // Read a burst against er[]; abort_beat >= 0 pulses rst while that beat is presented.
  task automatic do_read(input logic [31:0] addr, input logic [15:0] id, input int len,
                         input int rdelay, input int abort_beat);
    int t;
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    bus.arid    = id;
    bus.arlen   = 8'(len);
    t = 0;
    while (bus.arready !== 1'b1 && t < 50) begin step(); t++; end
    check("ar_ready_wait", 64'(t < 50), 64'd1);
    step();
    bus.arvalid = 1'b0;
    check("rvalid_t1", 64'(bus.rvalid), 64'd0);
    for (int i = 0; i <= len; i++) begin
      step();
      check($sformatf("rvalid_b%0d", i), 64'(bus.rvalid), 64'd1);
      check($sformatf("rdata_b%0d", i), bus.rdata, er[i]);
      check($sformatf("rid_b%0d", i), 64'(bus.rid), 64'(id));
      check($sformatf("rlast_b%0d", i), 64'(bus.rlast), 64'(i == len));
      check($sformatf("rresp_b%0d", i), 64'(bus.rresp), 64'(RESP_OKAY));
      if (i == abort_beat) begin
        rst = 1'b1;
        step();
        check("rvalid_in_rst", 64'(bus.rvalid), 64'd0);
        check("arready_in_rst", 64'(bus.arready), 64'd0);
        rst = 1'b0;
        step();
        check("arready_after_rst", 64'(bus.arready), 64'd1);
        check("awready_after_rst", 64'(bus.awready), 64'd1);
        return;
      end
      if (i == 0) begin
        for (int d = 0; d < rdelay; d++) begin
          step();
          check("rvalid_hold", 64'(bus.rvalid), 64'd1);
          check("rdata_hold", bus.rdata, er[0]);
          check("rlast_hold", 64'(bus.rlast), 64'(len == 0));
        end
      end
      bus.rready = 1'b1;
      step();
      bus.rready = 1'b0;
      check($sformatf("rvalid_gap_b%0d", i), 64'(bus.rvalid), 64'd0);
      if (i == len) check("arready_after_r", 64'(bus.arready), 64'd1);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
    bus.rready  = 1'b0;
    repeat (3) step();

    check("rst_awready", 64'(bus.awready), 64'd0);
    check("rst_arready", 64'(bus.arready), 64'd0);
    check("rst_wready",  64'(bus.wready),  64'd0);
    check("rst_bvalid",  64'(bus.bvalid),  64'd0);
    check("rst_rvalid",  64'(bus.rvalid),  64'd0);
    check("rst_rlast",   64'(bus.rlast),   64'd0);
    check("rst_rdata",   bus.rdata,        64'd0);
    check("rst_bid",     64'(bus.bid),     64'd0);
    check("rst_rid",     64'(bus.rid),     64'd0);
    rst = 1'b0;
    step();
    check("awready_post_rst", 64'(bus.awready), 64'd1);
    check("arready_post_rst", 64'(bus.arready), 64'd1);

    // Single-beat write and read-back.
    set_beats(64'h1122334455667788, 0);
    do_write(32'h10, 16'h1234, 0, 0, RESP_OKAY);
    do_read(32'h10, 16'hBEEF, 0, 0, -1);

    // Partial strobe on beat 1 over all-ones background.
    set_beats(64'hFFFFFFFFFFFFFFFF, 3);
    for (int i = 0; i < 4; i++) wd[i] = 64'hFFFFFFFFFFFFFFFF;
    do_write(32'h100, 16'h0001, 3, 0, RESP_OKAY);
    set_beats(64'h0123456789ABCDE0, 3);
    ws[1] = 8'h0F;
    er[1] = 64'hFFFFFFFF89ABCDE1;
    do_write(32'h100, 16'h0002, 3, 0, RESP_OKAY);
    do_read(32'h100, 16'h0003, 3, 0, -1);

    // Early wlast: both beats land, SLVERR.
    set_beats(64'hAAAAAAAA00000000, 1);
    wl[0] = 1'b1; wl[1] = 1'b0;
    do_write(32'h200, 16'h0A0A, 1, 0, RESP_SLVERR);
    do_read(32'h200, 16'h0B0B, 1, 0, -1);

    // Missing wlast: SLVERR, data written.
    set_beats(64'hBBBBBBBB00000010, 1);
    wl[1] = 1'b0;
    do_write(32'h300, 16'h0C0C, 1, 0, RESP_SLVERR);
    do_read(32'h300, 16'h0D0D, 1, 0, -1);

    // Backpressure on B and R.
    set_beats(64'h5555AAAA5555AAAA, 0);
    do_write(32'h500, 16'h7777, 0, 3, RESP_OKAY);
    do_read(32'h500, 16'h8888, 0, 5, -1);

    // Same-cycle AW/AR to word 0x10: read sees pre-write value.
    bus.awvalid = 1'b1; bus.awaddr = 32'h10; bus.awid = 16'h4444; bus.awlen = 8'd0;
    bus.arvalid = 1'b1; bus.araddr = 32'h10; bus.arid = 16'h5555; bus.arlen = 8'd0;
    check("cc_awready", 64'(bus.awready), 64'd1);
    check("cc_arready", 64'(bus.arready), 64'd1);
    step();
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 64'hCAFEF00DDEADBEEF; bus.wstrb = 8'hFF; bus.wlast = 1'b1;
    step();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("cc_rvalid", 64'(bus.rvalid), 64'd1);
    check("cc_rdata_old", bus.rdata, 64'h1122334455667788);
    check("cc_rid", 64'(bus.rid), 64'h5555);
    check("cc_bvalid", 64'(bus.bvalid), 64'd1);
    check("cc_bresp", 64'(bus.bresp), 64'(RESP_OKAY));
    bus.rready = 1'b1; bus.bready = 1'b1;
    step();
    bus.rready = 1'b0; bus.bready = 1'b0;
    check("cc_rvalid_drop", 64'(bus.rvalid), 64'd0);
    check("cc_bvalid_drop", 64'(bus.bvalid), 64'd0);
    set_beats(64'hCAFEF00DDEADBEEF, 0);
    do_read(32'h10, 16'h6666, 0, 0, -1);

    // Reset during beat 2 of an 8-beat read, then a clean re-read.
    set_beats(64'h0000100000000000, 7);
    do_write(32'h400, 16'h0400, 7, 0, RESP_OKAY);
    do_read(32'h400, 16'h0401, 7, 0, 2);
    do_read(32'h400, 16'h0402, 7, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
